// File: rtl/mfp_pkg.sv
// mfp_pkg: shared constants for the MFP68901 interrupt controller slice.
//   - register indices decoded by mfp_irq_ctrl (IERA..VR)
//   - channel numbers of the fixed interrupt sources (bit n = channel n)
//   - handshake FSM state encoding
package mfp_pkg;

   // Register indices on the MFP register bus
   localparam logic [4:0] MFP_IERA = 5'h03;
   localparam logic [4:0] MFP_IERB = 5'h04;
   localparam logic [4:0] MFP_IPRA = 5'h05;
   localparam logic [4:0] MFP_IPRB = 5'h06;
   localparam logic [4:0] MFP_ISRA = 5'h07;
   localparam logic [4:0] MFP_ISRB = 5'h08;
   localparam logic [4:0] MFP_IMRA = 5'h09;
   localparam logic [4:0] MFP_IMRB = 5'h0A;
   localparam logic [4:0] MFP_VR   = 5'h0B;

   // Channel numbers; A bank = 15..8, B bank = 7..0, 15 = highest priority
   localparam int CH_TMRA  = 13;
   localparam int CH_TMRB  = 8;
   localparam int CH_TMRC  = 5;
   localparam int CH_TMRD  = 4;
   localparam int CH_GPIP0 = 0;
   localparam int CH_GPIP1 = 1;
   localparam int CH_GPIP2 = 2;
   localparam int CH_GPIP3 = 3;
   localparam int CH_GPIP4 = 6;
   localparam int CH_GPIP5 = 7;
   localparam int CH_GPIP6 = 14;
   localparam int CH_GPIP7 = 15;

   // Acknowledge handshake states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_ACK     = 2'd2;

endpackage

// File: rtl/mfp_prio_enc.sv
// mfp_prio_enc: 16-bit highest-set-bit encoder.
// Ports:
//   vec   in  16  request vector, bit 15 = highest priority
//   valid out  1  any bit of vec set
//   idx   out  4  index of the highest set bit (0 when valid=0)
module mfp_prio_enc (
   input  logic [15:0] vec,
   output logic        valid,
   output logic [3:0]  idx
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      valid = 1'b0;
      idx   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (vec[i]) begin
            valid = 1'b1;
            idx   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: MFP68901 interrupt controller.
// Holds IER/IPR/ISR/IMR (16 channels, A = 15..8, B = 7..0) and VR, resolves the
// highest eligible channel, drives IRQ and delivers a vector on acknowledge.
// Ports:
//   CLK       in   1  system clock
//   RST       in   1  synchronous active-high reset
//   IRQ_EVT   in  16  one-cycle channel event pulses
//   ADDR      in   5  register index
//   REG_WE    in   1  write strobe (DAT_I -> ADDR)
//   DAT_I     in   8  write data
//   DAT_O     out  8  combinational read data for ADDR (00 for unowned indices)
//   IACK      in   1  acknowledge pulse from the CPU side
//   IRQ       out  1  registered interrupt request
//   VEC_VALID out  1  one-cycle pulse, VECTOR/NOVEC valid
//   VECTOR    out  8  {VR[7:4], channel}
//   NOVEC     out  1  spurious acknowledge (nothing eligible)
module mfp_irq_ctrl
   import mfp_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] IRQ_EVT,
   input  logic [4:0]  ADDR,
   input  logic        REG_WE,
   input  logic [7:0]  DAT_I,
   output logic [7:0]  DAT_O,
   input  logic        IACK,
   output logic        IRQ,
   output logic        VEC_VALID,
   output logic [7:0]  VECTOR,
   output logic        NOVEC
);

   logic [15:0] ier_reg, ipr_reg, isr_reg, imr_reg;
   logic [15:0] ier_next, ipr_next, isr_next, imr_next;
   logic [7:0]  vr_reg, vr_next;
   logic [7:0]  vector_reg;
   logic        novec_reg, irq_reg;
   logic [1:0]  state_reg, state_next;

   logic        isr_valid, win_valid;
   logic [3:0]  isr_idx, win_idx;
   logic [15:0] allow, eligible, ack_bit;
   logic        resolving;

   // Decoded write strobes
   wire wr_iera = REG_WE && (ADDR == MFP_IERA);
   wire wr_ierb = REG_WE && (ADDR == MFP_IERB);
   wire wr_ipra = REG_WE && (ADDR == MFP_IPRA);
   wire wr_iprb = REG_WE && (ADDR == MFP_IPRB);
   wire wr_isra = REG_WE && (ADDR == MFP_ISRA);
   wire wr_isrb = REG_WE && (ADDR == MFP_ISRB);
   wire wr_imra = REG_WE && (ADDR == MFP_IMRA);
   wire wr_imrb = REG_WE && (ADDR == MFP_IMRB);
   wire wr_vr   = REG_WE && (ADDR == MFP_VR);

   // Bits written as 0 into IER/IPR/ISR act as clear masks
   wire [15:0] ier_zero = {wr_iera ? ~DAT_I : 8'h00, wr_ierb ? ~DAT_I : 8'h00};
   wire [15:0] ipr_zero = {wr_ipra ? ~DAT_I : 8'h00, wr_iprb ? ~DAT_I : 8'h00};
   wire [15:0] isr_zero = {wr_isra ? ~DAT_I : 8'h00, wr_isrb ? ~DAT_I : 8'h00};
   wire        s_mode   = vr_reg[3];
   wire        isr_wipe = wr_vr && !DAT_I[3];

   mfp_prio_enc u_isr_enc (.vec(isr_reg),  .valid(isr_valid), .idx(isr_idx));
   mfp_prio_enc u_win_enc (.vec(eligible), .valid(win_valid), .idx(win_idx));

   // In S mode only channels above the highest in-service one may interrupt.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_allow
         assign allow[gi] = !s_mode || !isr_valid || (4'(gi) > isr_idx);
      end
   endgenerate

   assign eligible  = ipr_reg & imr_reg & allow;
   assign resolving = (state_reg == ST_RESOLVE);
   assign ack_bit   = (resolving && win_valid) ? (16'h0001 << win_idx) : 16'h0000;

   always_comb begin
      // IPR: a new event beats acknowledge/write clears; an IER 0-write beats all.
      ipr_next = ((ipr_reg & ~ack_bit & ~ipr_zero) | (IRQ_EVT & ier_reg)) & ~ier_zero;
      // ISR: acknowledge set beats ISR write clear; VR write with S=0 beats both.
      isr_next = (isr_reg & ~isr_zero) | (s_mode ? ack_bit : 16'h0000);
      if (isr_wipe)
         isr_next = 16'h0000;

      ier_next = {wr_iera ? DAT_I : ier_reg[15:8], wr_ierb ? DAT_I : ier_reg[7:0]};
      imr_next = {wr_imra ? DAT_I : imr_reg[15:8], wr_imrb ? DAT_I : imr_reg[7:0]};
      vr_next  = wr_vr ? DAT_I : vr_reg;

      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (IACK) state_next = ST_RESOLVE;
         ST_RESOLVE: state_next = ST_ACK;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ier_reg    <= 16'h0000;
         ipr_reg    <= 16'h0000;
         isr_reg    <= 16'h0000;
         imr_reg    <= 16'h0000;
         vr_reg     <= 8'h00;
         irq_reg    <= 1'b0;
         vector_reg <= 8'h00;
         novec_reg  <= 1'b0;
         state_reg  <= ST_IDLE;
      end else begin
         ier_reg   <= ier_next;
         ipr_reg   <= ipr_next;
         isr_reg   <= isr_next;
         imr_reg   <= imr_next;
         vr_reg    <= vr_next;
         irq_reg   <= |eligible;
         state_reg <= state_next;
         if (resolving) begin
            vector_reg <= win_valid ? {vr_reg[7:4], win_idx} : 8'h00;
            novec_reg  <= !win_valid;
         end
      end
   end

   always_comb begin
      DAT_O = 8'h00;
      case (ADDR)
         MFP_IERA: DAT_O = ier_reg[15:8];
         MFP_IERB: DAT_O = ier_reg[7:0];
         MFP_IPRA: DAT_O = ipr_reg[15:8];
         MFP_IPRB: DAT_O = ipr_reg[7:0];
         MFP_ISRA: DAT_O = isr_reg[15:8];
         MFP_ISRB: DAT_O = isr_reg[7:0];
         MFP_IMRA: DAT_O = imr_reg[15:8];
         MFP_IMRB: DAT_O = imr_reg[7:0];
         MFP_VR:   DAT_O = vr_reg;
         default:  DAT_O = 8'h00;
      endcase
   end

   assign IRQ       = irq_reg;
   assign VEC_VALID = (state_reg == ST_ACK);
   assign VECTOR    = vector_reg;
   assign NOVEC     = novec_reg;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
module tb_mfp_irq_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] IRQ_EVT = '0;
   logic [4:0]  ADDR = '0;
   logic        REG_WE = 1'b0;
   logic [7:0]  DAT_I = '0;
   logic        IACK = 1'b0;
   logic [7:0]  DAT_O, VECTOR;
   logic        IRQ, VEC_VALID, NOVEC;

   mfp_irq_ctrl dut (
      .CLK(CLK), .RST(RST), .IRQ_EVT(IRQ_EVT), .ADDR(ADDR), .REG_WE(REG_WE),
      .DAT_I(DAT_I), .DAT_O(DAT_O), .IACK(IACK), .IRQ(IRQ),
      .VEC_VALID(VEC_VALID), .VECTOR(VECTOR), .NOVEC(NOVEC)
   );

   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] m_ier, m_ipr, m_isr, m_imr;
   logic [7:0]  m_vr, m_vec;
   logic        m_irq, m_novec;
   int          m_phase;   // cycles since an accepted acknowledge: 0 none, 1 resolving, 2 vector out
   bit          m_live = 0;

   function automatic logic [15:0] m_elig();
      logic [15:0] e;
      int top_isr;
      top_isr = -1;
      for (int n = 0; n < 16; n++) if (m_isr[n]) top_isr = n;
      for (int n = 0; n < 16; n++)
         e[n] = m_ipr[n] && m_imr[n] && (!m_vr[3] || n > top_isr);
      return e;
   endfunction

   // true when this cycle writes a 0 into channel n of the register pair (a_idx, b_idx)
   function automatic bit m_zero_wr(int n, logic [4:0] a_idx, logic [4:0] b_idx);
      logic [4:0] want;
      want = (n >= 8) ? a_idx : b_idx;
      return REG_WE && ADDR == want && !DAT_I[n % 8];
   endfunction

   function automatic logic [7:0] m_read(logic [4:0] a);
      case (a)
         5'h03: return m_ier[15:8];
         5'h04: return m_ier[7:0];
         5'h05: return m_ipr[15:8];
         5'h06: return m_ipr[7:0];
         5'h07: return m_isr[15:8];
         5'h08: return m_isr[7:0];
         5'h09: return m_imr[15:8];
         5'h0A: return m_imr[7:0];
         5'h0B: return m_vr;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge CLK) begin
      if (RST) begin
         m_ier = 0; m_ipr = 0; m_isr = 0; m_imr = 0; m_vr = 0;
         m_vec = 0; m_novec = 0; m_irq = 0; m_phase = 0; m_live = 1;
      end else if (m_live) begin
         logic [15:0] e, ipr_n, isr_n;
         int w;
         e = m_elig();
         w = -1;
         if (m_phase == 1) begin
            for (int n = 0; n < 16; n++) if (e[n]) w = n;
            m_novec = (w < 0);
            m_vec   = (w < 0) ? 8'h00 : {m_vr[7:4], 4'(w)};
         end
         for (int n = 0; n < 16; n++) begin
            bit b;
            b = m_ipr[n];
            if (w == n) b = 0;
            if (m_zero_wr(n, 5'h05, 5'h06)) b = 0;
            if (IRQ_EVT[n] && m_ier[n]) b = 1;
            if (m_zero_wr(n, 5'h03, 5'h04)) b = 0;
            ipr_n[n] = b;
            b = m_isr[n];
            if (m_zero_wr(n, 5'h07, 5'h08)) b = 0;
            if (w == n && m_vr[3]) b = 1;
            if (REG_WE && ADDR == 5'h0B && !DAT_I[3]) b = 0;
            isr_n[n] = b;
         end
         m_ipr = ipr_n;
         m_isr = isr_n;
         if (REG_WE) begin
            case (ADDR)
               5'h03: m_ier[15:8] = DAT_I;
               5'h04: m_ier[7:0]  = DAT_I;
               5'h09: m_imr[15:8] = DAT_I;
               5'h0A: m_imr[7:0]  = DAT_I;
               5'h0B: m_vr        = DAT_I;
               default: ;
            endcase
         end
         m_irq = |e;
         if (m_phase == 0) m_phase = IACK ? 1 : 0;
         else if (m_phase == 1) m_phase = 2;
         else m_phase = 0;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge CLK) begin
      if (m_live) begin
         chk("irq", 16'(IRQ), 16'(m_irq));
         chk("vec_valid", 16'(VEC_VALID), 16'(m_phase == 2));
         chk("vector", 16'(VECTOR), 16'(m_vec));
         chk("novec", 16'(NOVEC), 16'(m_novec));
         chk("dat_o", 16'(DAT_O), 16'(m_read(ADDR)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
      REG_WE = 0; IRQ_EVT = '0; IACK = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      ADDR = a; DAT_I = d; REG_WE = 1;
      cyc();
   endtask

   // Lands just after the falling edge, after the compare process has sampled
   task automatic at_neg();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      RST = 1;
      repeat (3) cyc();
      RST = 0;

      // Reset state of every register
      for (int a = 3; a <= 11; a++) begin
         ADDR = 5'(a);
         at_neg();
         chk($sformatf("reset_reg_%0h", a), 16'(DAT_O), 16'h00);
      end
      chk("reset_irq", 16'(IRQ), 16'h0);
      chk("reset_vv", 16'(VEC_VALID), 16'h0);

      // 1: Timer A
      wr(5'h03, 8'h20); wr(5'h09, 8'h20); wr(5'h0B, 8'h40);
      ADDR = 5'h05; IRQ_EVT = 16'h2000; cyc();
      at_neg(); chk("t1_ipra", 16'(DAT_O), 16'h20); chk("t1_irq_early", 16'(IRQ), 16'h0);
      at_neg(); chk("t1_irq", 16'(IRQ), 16'h1);
      IACK = 1; cyc();
      at_neg(); chk("t1_vv_resolve", 16'(VEC_VALID), 16'h0);
      at_neg(); chk("t1_vv", 16'(VEC_VALID), 16'h1); chk("t1_vector", 16'(VECTOR), 16'h4D);
      chk("t1_novec", 16'(NOVEC), 16'h0); chk("t1_ipra_clr", 16'(DAT_O), 16'h00);
      at_neg(); chk("t1_irq_drop", 16'(IRQ), 16'h0); chk("t1_vv_pulse", 16'(VEC_VALID), 16'h0);

      // 2: S-mode nesting
      wr(5'h0B, 8'h48); wr(5'h03, 8'h21); wr(5'h09, 8'h21); wr(5'h04, 8'h10); wr(5'h0A, 8'h10);
      IRQ_EVT = 16'h0010; cyc();
      IRQ_EVT = 16'h2000; cyc(); cyc();
      ADDR = 5'h07; IACK = 1; cyc();
      at_neg();
      at_neg(); chk("t2_vector", 16'(VECTOR), 16'h4D); chk("t2_isra", 16'(DAT_O), 16'h20);
      IRQ_EVT = 16'h0100; cyc(); cyc(); cyc();
      at_neg(); chk("t2_irq_blocked", 16'(IRQ), 16'h0);
      wr(5'h07, 8'hDF);
      at_neg();
      at_neg(); chk("t2_irq_after_eoi", 16'(IRQ), 16'h1);
      ADDR = 5'h07; IACK = 1; cyc();
      at_neg();
      at_neg(); chk("t2_vector_ch8", 16'(VECTOR), 16'h48); chk("t2_isra_ch8", 16'(DAT_O), 16'h01);
      wr(5'h0B, 8'h40); wr(5'h05, 8'h00); wr(5'h06, 8'h00);

      // 3: masking
      wr(5'h0A, 8'h00);
      IRQ_EVT = 16'h0010; ADDR = 5'h06; cyc();
      at_neg(); chk("t3_iprb", 16'(DAT_O), 16'h10);
      at_neg(); chk("t3_irq_masked", 16'(IRQ), 16'h0);
      wr(5'h0A, 8'h10);
      at_neg();
      at_neg(); chk("t3_irq_unmasked", 16'(IRQ), 16'h1);
      wr(5'h04, 8'h00); ADDR = 5'h06;
      at_neg(); chk("t3_iprb_clr", 16'(DAT_O), 16'h00);
      at_neg(); chk("t3_irq_off", 16'(IRQ), 16'h0);

      // 4: spurious acknowledge
      ADDR = 5'h05; IACK = 1; cyc();
      at_neg();
      at_neg(); chk("t4_vv", 16'(VEC_VALID), 16'h1); chk("t4_novec", 16'(NOVEC), 16'h1);
      chk("t4_vector", 16'(VECTOR), 16'h00); chk("t4_ipra", 16'(DAT_O), 16'h00);

      // 5: collisions
      ADDR = 5'h05; DAT_I = 8'h00; REG_WE = 1; IRQ_EVT = 16'h2000; cyc();
      at_neg(); chk("t5_ipra_set_wins", 16'(DAT_O), 16'h20);
      wr(5'h0B, 8'h48);
      IACK = 1; cyc();
      ADDR = 5'h0B; DAT_I = 8'h40; REG_WE = 1; cyc();
      ADDR = 5'h07;
      at_neg(); chk("t5_vector", 16'(VECTOR), 16'h4D); chk("t5_isra_vr_wins", 16'(DAT_O), 16'h00);
      wr(5'h05, 8'h00);

      // 6: reset while resolving
      IRQ_EVT = 16'h2000; cyc(); cyc();
      IACK = 1; cyc();
      RST = 1; cyc();
      RST = 0; ADDR = 5'h03;
      at_neg(); chk("t6_vv", 16'(VEC_VALID), 16'h0); chk("t6_iera", 16'(DAT_O), 16'h00);
      chk("t6_irq", 16'(IRQ), 16'h0);
      at_neg(); chk("t6_vv_late", 16'(VEC_VALID), 16'h0);

      // Randomized traffic, checked every cycle by the compare process
      wr(5'h03, 8'hFF); wr(5'h04, 8'hFF); wr(5'h09, 8'hFF); wr(5'h0A, 8'hFF);
      for (int i = 0; i < 3000; i++) begin
         IRQ_EVT = 16'($urandom) & 16'($urandom) & 16'($urandom);
         IACK = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 5) == 0) begin
            REG_WE = 1;
            ADDR = 5'($urandom_range(3, 11));
            DAT_I = 8'($urandom);
         end else begin
            ADDR = 5'($urandom_range(0, 15));
         end
         RST = ($urandom_range(0, 599) == 0);
         cyc();
         RST = 0;
      end

      at_neg();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
